// File: rtl/tt_um_bnn.sv
// tt_um_bnn: one binarized neural-network layer of 8 neurons.
// Each neuron i holds an 8-bit weight W[i] and a 4-bit threshold T[i]. An
// inference latches an 8-bit activation A and evaluates one neuron per cycle,
// where out[i] = popcount(~(A ^ W[i])) >= T[i]. The 8 result bits appear on
// uo_out together when the inference finishes.
//
// Ports:
//   clk     : rising-edge clock for all state
//   rst_n   : synchronous reset, active HIGH (the name is historical)
//   ena     : design select, not used by the logic
//   ui_in   : data byte (weight, threshold in [3:0], or activation)
//   uio_in  : [2:0] command, [5:3] neuron index, [7:6] unused
//   uo_out  : result register, bit i = output of neuron i
//   uio_out : [7] done, [6] busy, [5:0] always 0
//   uio_oe  : constant 8'hC0
module tt_um_bnn (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned N_NEURON = 8;
   localparam int unsigned DW       = 8;
   localparam int unsigned TW       = 4;
   localparam int unsigned IW       = 3;

   localparam logic [2:0] CMD_LD_W  = 3'b001;
   localparam logic [2:0] CMD_LD_T  = 3'b010;
   localparam logic [2:0] CMD_START = 3'b011;

   localparam logic [TW-1:0] T_RST = TW'(4);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   acc_q;
   logic            busy_q;
   logic            done_q;
   logic [DW-1:0]   w_q [N_NEURON];
   logic [TW-1:0]   t_q [N_NEURON];

   logic [2:0]      cmd;
   logic [IW-1:0]   idx;
   logic            ld_w_c;
   logic            ld_t_c;
   logic            start_c;
   logic            step_c;
   logic            last_c;
   logic [DW-1:0]   match_c;
   logic [TW-1:0]   pop_c;
   logic            fire_c;

   // ena and the spare uio_in bits carry no meaning for this layer
   logic unused_inputs;
   assign unused_inputs = &{1'b0, ena, uio_in[7:6]};

   assign cmd = uio_in[2:0];
   assign idx = uio_in[5:3];

   // State register
   always_ff @(posedge clk) begin
      if (rst_n) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and command decode; commands only act while idle
   always_comb begin
      state_d = state_q;
      ld_w_c  = 1'b0;
      ld_t_c  = 1'b0;
      start_c = 1'b0;
      step_c  = 1'b0;
      last_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            case (cmd)
               CMD_LD_W:  ld_w_c = 1'b1;
               CMD_LD_T:  ld_t_c = 1'b1;
               CMD_START: begin
                  start_c = 1'b1;
                  state_d = ST_RUN;
               end
               default: ;
            endcase
         end
         ST_RUN: begin
            step_c = 1'b1;
            if (cnt_q == IW'(N_NEURON - 1)) begin
               last_c  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Evaluate the neuron selected by the counter
   always_comb begin
      match_c = ~(a_q ^ w_q[cnt_q]);
      pop_c   = '0;
      for (int b = 0; b < int'(DW); b++) begin
         pop_c = pop_c + TW'(match_c[b]);
      end
      fire_c = (pop_c >= t_q[cnt_q]);
   end

   // Datapath: parameter registers, activation, accumulator and result
   always_ff @(posedge clk) begin
      if (rst_n) begin
         cnt_q  <= '0;
         a_q    <= '0;
         acc_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         uo_out <= '0;
         for (int i = 0; i < int'(N_NEURON); i++) begin
            w_q[i] <= '0;
            t_q[i] <= T_RST;
         end
      end else begin
         if (ld_w_c) w_q[idx] <= ui_in;
         if (ld_t_c) t_q[idx] <= ui_in[TW-1:0];
         if (start_c) begin
            a_q    <= ui_in;
            cnt_q  <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
         end
         if (step_c) begin
            acc_q[cnt_q] <= fire_c;
            cnt_q        <= cnt_q + IW'(1);
         end
         // The last neuron's bit bypasses the accumulator so all 8 land together
         if (last_c) begin
            uo_out <= {fire_c, acc_q[DW-2:0]};
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   assign uio_out = {done_q, busy_q, 6'b000000};
   assign uio_oe  = 8'hC0;

endmodule

// File: tb/tb_tt_um_bnn.sv
// Directed self-checking bench for tt_um_bnn.
module tb_tt_um_bnn;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] prev_exp;

   localparam logic [2:0] NOP   = 3'b000;
   localparam logic [2:0] LD_W  = 3'b001;
   localparam logic [2:0] LD_T  = 3'b010;
   localparam logic [2:0] START = 3'b011;

   tt_um_bnn dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
   endtask

   // Present a command for exactly one rising edge; starts and ends at a negedge
   task automatic issue(input logic [2:0] c, input logic [2:0] idx, input logic [7:0] d);
      ui_in  = d;
      uio_in = {2'b00, idx, c};
      @(posedge clk);
      #1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      @(negedge clk);
   endtask

   // Full inference with timing checks; previous result must hold until E8
   task automatic run_inf(input string tag, input logic [7:0] a, input logic [7:0] exp);
      issue(START, 3'd0, a);
      chk({tag, "_busy_e0"}, {7'd0, uio_out[6]}, 8'h01);
      chk({tag, "_done_e0"}, {7'd0, uio_out[7]}, 8'h00);
      repeat (7) @(negedge clk);
      chk({tag, "_busy_e7"}, {7'd0, uio_out[6]}, 8'h01);
      chk({tag, "_hold_e7"}, uo_out, prev_exp);
      chk({tag, "_low_e7"}, {2'b00, uio_out[5:0]}, 8'h00);
      @(negedge clk);
      chk({tag, "_status"}, uio_out, 8'h80);
      chk({tag, "_result"}, uo_out, exp);
      prev_exp = exp;
   endtask

   initial begin
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      rst_n  = 1'b1;
      prev_exp = 8'h00;

      // Reset held for two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_oe", uio_oe, 8'hC0);
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      rst_n = 1'b0;
      @(negedge clk);

      // Default W=0, T=4: ~A popcount vs 4
      run_inf("def0f", 8'h0F, 8'hFF);
      issue(3'b111, 3'd2, 8'h55);
      issue(3'b100, 3'd1, 8'hAA);
      repeat (2) @(negedge clk);
      chk("done_hold", uio_out, 8'h80);
      chk("nop_keep", uo_out, 8'hFF);
      run_inf("def1f", 8'h1F, 8'h00);

      // Load weights/thresholds of neurons 0 and 7
      issue(LD_W, 3'd0, 8'hFF);
      issue(LD_T, 3'd0, 8'h08);
      issue(LD_W, 3'd7, 8'hAA);
      issue(LD_T, 3'd7, 8'h08);
      run_inf("ld_ff", 8'hFF, 8'h01);
      // Neurons 1-6 (W=0) see p=4 against default T=4 and fire
      run_inf("ld_aa", 8'hAA, 8'hFE);

      // Threshold bounds on neuron 3
      issue(LD_T, 3'd3, 8'h00);
      run_inf("t0", 8'hFF, 8'h09);
      issue(LD_W, 3'd3, 8'h3C);
      issue(LD_T, 3'd3, 8'h08);
      run_inf("t8", 8'h3C, 8'h7E);
      issue(LD_T, 3'd3, 8'h09);
      run_inf("t9", 8'h3C, 8'h76);
      issue(LD_T, 3'd3, 8'hFF);
      run_inf("t15", 8'h3C, 8'h76);

      // Busy lockout: START and loads during inference, plus a load at E8
      issue(START, 3'd0, 8'hFF);
      chk("lock_busy", {7'd0, uio_out[6]}, 8'h01);
      issue(START, 3'd0, 8'h00);
      issue(LD_W, 3'd0, 8'h00);
      repeat (5) @(negedge clk);
      chk("lock_hold", uo_out, prev_exp);
      issue(LD_W, 3'd0, 8'h00);
      chk("lock_status", uio_out, 8'h80);
      chk("lock_result", uo_out, 8'h01);
      prev_exp = 8'h01;
      // Back-to-back read-back: W[0] must still be 0xFF
      run_inf("readback", 8'hFF, 8'h01);

      // Reset at E4 of an inference
      issue(START, 3'd0, 8'h0F);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      chk("mrst_uio", uio_out, 8'h00);
      chk("mrst_uo", uo_out, 8'h00);
      chk("mrst_oe", uio_oe, 8'hC0);
      repeat (9) @(negedge clk);
      chk("mrst_nocommit", uo_out, 8'h00);
      prev_exp = 8'h00;
      run_inf("mrst_def", 8'h0F, 8'hFF);
      run_inf("mrst_def1", 8'hAA, 8'hFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
